// File: rtl/rotate_left_seq.sv
// Sequential rotate/shift-left unit: one step per cycle over CNT steps (ROL, SHL, RCL).
// Define ROTL_RCL_EN to build the rotate-through-carry datapath; otherwise MODE=10 runs as ROL.
module rotate_left_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [4:0]       CNT,
  input  logic [1:0]       MODE,
  input  logic             CIN,
  output logic [WIDTH-1:0] R,
  output logic             CF,
  output logic             OF,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             cf_q, cf_d;
  logic             of_q, of_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             step_lsb;

  // Bit shifted into R[0]; ROL is the fallback for SHL-less and reserved encodings.
  always_comb begin
    step_lsb = r_q[WIDTH-1];
    if (mode_q == 2'b01) begin
      step_lsb = 1'b0;
    end
`ifdef ROTL_RCL_EN
    else if (mode_q == 2'b10) begin
      step_lsb = cf_q;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    cf_d    = cf_q;
    of_d    = of_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          r_d     = A;
          cf_d    = CIN;
          of_d    = 1'b0;
          mode_d  = MODE;
          cnt_d   = CNT;
          state_d = (CNT == 5'd0) ? StDone : StRun;
        end
      end
      StRun: begin
        r_d   = {r_q[WIDTH-2:0], step_lsb};
        cf_d  = r_q[WIDTH-1];
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          // Overflow compares the post-step MSB with the post-step carry.
          of_d    = r_q[WIDTH-2] ^ r_q[WIDTH-1];
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      r_q     <= '0;
      cf_q    <= 1'b0;
      of_q    <= 1'b0;
      cnt_q   <= 5'd0;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cf_q    <= cf_d;
      of_q    <= of_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  assign R    = r_q;
  assign CF   = cf_q;
  assign OF   = of_q;
  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_rotate_left_seq.sv
// Directed + scoreboard bench for rotate_left_seq; expected results queued at issue, checked at done.
module tb_rotate_left_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] A;
  logic [4:0]  CNT;
  logic [1:0]  MODE;
  logic        CIN;
  logic [15:0] R;
  logic        CF;
  logic        OF;
  logic        busy;
  logic        done;

  rotate_left_seq #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .CNT   (CNT),
    .MODE  (MODE),
    .CIN   (CIN),
    .R     (R),
    .CF    (CF),
    .OF    (OF),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] r;
    logic        cf;
    logic        of;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [15:0] a, input logic [4:0] cnt, input logic [1:0] mode,
                                input logic cin, output logic [15:0] r, output logic cf,
                                output logic of);
    logic msb, lsb;
    r  = a;
    cf = cin;
    of = 1'b0;
    for (int i = 0; i < int'(cnt); i++) begin
      msb = r[15];
      lsb = msb;
      if (mode == 2'b01) lsb = 1'b0;
`ifdef ROTL_RCL_EN
      if (mode == 2'b10) lsb = cf;
`endif
      r  = {r[14:0], lsb};
      cf = msb;
    end
    if (cnt != 5'd0) of = r[15] ^ cf;
  endfunction

  // Called at a negedge. Issues one op, scrambles inputs after acceptance, waits for done.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [4:0] cnt,
                        input logic [1:0] mode, input logic cin, input logic [15:0] er,
                        input logic ecf, input logic eof, input bit inject);
    exp_t e;
    int   edges;
    bit   seen;
    e.r   = er;
    e.cf  = ecf;
    e.of  = eof;
    e.lat = (cnt == 5'd0) ? 1 : int'(cnt) + 1;
    sb.push_back(e);
    A = a; CNT = cnt; MODE = mode; CIN = cin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = 16'($urandom); CNT = 5'($urandom); MODE = 2'($urandom); CIN = 1'($urandom);
    edges = 1;
    seen  = 1'b0;
    @(negedge clk);
    while (!seen && edges <= 40) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (inject) begin
          start = 1'b1;
          A     = 16'($urandom);
        end
        @(posedge clk); #1;
        start = 1'b0;
        edges++;
        @(negedge clk);
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    e = sb.pop_front();
    if (seen) begin
      chk({tag, "_latency"}, 32'(edges), 32'(e.lat));
      chk({tag, "_R"}, 32'(R), 32'(e.r));
      chk({tag, "_CF"}, 32'(CF), 32'(e.cf));
      chk({tag, "_OF"}, 32'(OF), 32'(e.of));
      chk({tag, "_busy_at_done"}, 32'(busy), 32'd1);
      // Start during the done cycle must be dropped.
      start = inject;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
      chk({tag, "_idle_after"}, 32'(busy), 32'd0);
      chk({tag, "_R_hold"}, 32'(R), 32'(e.r));
    end
  endtask

  initial begin
    logic [15:0] er;
    logic        ecf, eof;
    logic [15:0] ra;
    logic [4:0]  rc;
    logic [1:0]  rm;
    logic        rci;
    int          done_hits;

    rst = 1'b1; start = 1'b1; A = 16'hFFFF; CNT = 5'd3; MODE = 2'b00; CIN = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_R", 32'(R), 32'd0);
    chk("rst_CF", 32'(CF), 32'd0);
    chk("rst_OF", 32'(OF), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // First start accepted on the first edge with rst low.
    rst = 1'b0;
    run_op("rol_8001_1", 16'h8001, 5'd1, 2'b00, 1'b0, 16'h0003, 1'b1, 1'b1, 1'b0);
    run_op("rol_1234_4", 16'h1234, 5'd4, 2'b00, 1'b0, 16'h2341, 1'b1, 1'b1, 1'b1);
    run_op("shl_ffff_16", 16'hFFFF, 5'd16, 2'b01, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
`ifdef ROTL_RCL_EN
    run_op("rcl_0001_17", 16'h0001, 5'd17, 2'b10, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0);
`else
    run_op("rcl_0001_17", 16'h0001, 5'd17, 2'b10, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
`endif
    run_op("cnt0_beef", 16'hBEEF, 5'd0, 2'b00, 1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b1);
    run_op("rsv_8000_1", 16'h8000, 5'd1, 2'b11, 1'b0, 16'h0001, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      ra  = 16'($urandom);
      rc  = 5'($urandom);
      rm  = 2'($urandom);
      rci = 1'($urandom);
      model(ra, rc, rm, rci, er, ecf, eof);
      run_op($sformatf("rand%0d", i), ra, rc, rm, rci, er, ecf, eof, (i % 2) == 1);
    end

    // Abort an in-flight ROL by reset during its third RUN cycle.
    A = 16'hA5C3; CNT = 5'd10; MODE = 2'b00; CIN = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("abort_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_R", 32'(R), 32'd0);
    chk("abort_CF", 32'(CF), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    done_hits = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) done_hits++;
    end
    chk("abort_no_done", 32'(done_hits), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
